// File: rtl/prga_prog_receiver_pkg.sv
// rtl/prga_prog_receiver_pkg.sv - shared state enum and default sizes for the bitstream receiver
package prga_prog_receiver_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 64;
  localparam int DEF_ADDR_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } prog_state_t;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prga_prog_receiver_if.sv
// rtl/prga_prog_receiver_if.sv - loader-side and config-memory-side signals of the bitstream receiver
interface prga_prog_receiver_if
  import prga_prog_receiver_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              prog_rst;
  logic              prog_we;
  logic              prog_din;
  logic              prog_done;
  logic              prog_dout;
  logic              prog_we_o;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              fabric_en;
  logic              err;

  modport master (
    output prog_rst, prog_we, prog_din, prog_done, cfg_ready,
    input  prog_dout, prog_we_o, cfg_we, cfg_addr, cfg_data, fabric_en, err
  );

  modport slave (
    input  prog_rst, prog_we, prog_din, prog_done, cfg_ready,
    output prog_dout, prog_we_o, cfg_we, cfg_addr, cfg_data, fabric_en, err
  );

endinterface

// File: rtl/prga_prog_deser.sv
// rtl/prga_prog_deser.sv - serial-to-parallel shifter with bit counter and word-complete strobe
module prga_prog_deser
  import prga_prog_receiver_pkg::*;
#(
  parameter  int WORD_W = DEF_WORD_W,
  localparam int CNT_W  = cnt_width(WORD_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_din,
  output logic [CNT_W-1:0]  o_bit_cnt,
  output logic              o_word_done,
  output logic [WORD_W-1:0] o_word
);

  // Only WORD_W-1 bits are stored: the final bit is taken straight from i_din
  // so the complete word is available on the edge that finishes it.
  logic [WORD_W-2:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;

  assign o_word      = {r_shift, i_din};
  assign o_word_done = i_en && (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign o_bit_cnt   = r_bit_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_clr) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_en) begin
      r_shift   <= o_word[WORD_W-2:0];
      r_bit_cnt <= o_word_done ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prga_prog_receiver.sv
// rtl/prga_prog_receiver.sv - serial bitstream receiver feeding a word-wide configuration memory
module prga_prog_receiver
  import prga_prog_receiver_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst_n,
  prga_prog_receiver_if.slave   bus
);

  localparam int BIT_CNT_W  = cnt_width(WORD_W);
  localparam int WORD_CNT_W = cnt_width(NUM_WORDS);

  prog_state_t           r_state;
  logic [WORD_CNT_W-1:0] r_word_cnt;
  logic                  r_cfg_we;
  logic [ADDR_W-1:0]     r_cfg_addr;
  logic [WORD_W-1:0]     r_cfg_data;
  logic                  r_fabric_en;
  logic                  r_err;
  logic                  r_dout;
  logic                  r_we_o;

  logic                  w_active;
  logic                  w_full;
  logic                  w_bit_en;
  logic                  w_hs;
  logic                  w_go_err;
  logic                  w_go_done;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic                  w_word_done;
  logic [WORD_W-1:0]     w_word;

  assign w_active = (r_state == ST_IDLE) || (r_state == ST_SHIFT);
  assign w_full   = (r_word_cnt == WORD_CNT_W'(NUM_WORDS));
  assign w_bit_en = w_active && bus.prog_we && !w_full;
  assign w_hs     = r_cfg_we && bus.cfg_ready;

  prga_prog_deser #(
    .WORD_W (WORD_W)
  ) u_deser (
    .i_clk       (prog_clk),
    .i_rst_n     (prog_rst_n),
    .i_clr       (bus.prog_rst),
    .i_en        (w_bit_en),
    .i_din       (bus.prog_din),
    .o_bit_cnt   (w_bit_cnt),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  // A bit arriving with prog_done is counted first; prog_done is judged only
  // on a cycle without a bit, so the check always sees the settled counters.
  always_comb begin
    w_go_err = 1'b0;
    if (w_active) begin
      if (bus.prog_we) begin
        w_go_err = w_full || (w_word_done && r_cfg_we && !bus.cfg_ready);
      end else if (bus.prog_done) begin
        w_go_err = (r_state == ST_IDLE) || !w_full || (w_bit_cnt != '0);
      end
    end
  end

  // A still-pending last word holds off DONE without being an error.
  assign w_go_done = (r_state == ST_SHIFT) && !bus.prog_we && bus.prog_done &&
                     w_full && (w_bit_cnt == '0) && !r_cfg_we;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_fabric_en <= 1'b0;
      r_err       <= 1'b0;
      r_dout      <= 1'b0;
      r_we_o      <= 1'b0;
    end else if (bus.prog_rst) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_fabric_en <= 1'b0;
      r_err       <= 1'b0;
      r_dout      <= 1'b0;
      r_we_o      <= 1'b0;
    end else begin
      r_dout <= w_active && bus.prog_din;
      r_we_o <= w_active && bus.prog_we;
      if (w_go_err) begin
        r_state     <= ST_ERROR;
        r_err       <= 1'b1;
        r_cfg_we    <= 1'b0;
        r_fabric_en <= 1'b0;
      end else begin
        if (w_hs) begin
          r_cfg_we <= 1'b0;
        end
        // A word finishing on the handshake cycle simply reloads the holding register.
        if (w_word_done) begin
          r_cfg_we   <= 1'b1;
          r_cfg_data <= w_word;
          r_cfg_addr <= ADDR_W'(r_word_cnt);
          r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
        end
        if ((r_state == ST_IDLE) && w_bit_en) begin
          r_state <= ST_SHIFT;
        end
        if (w_go_done) begin
          r_state     <= ST_DONE;
          r_fabric_en <= 1'b1;
        end
      end
    end
  end

  assign bus.prog_dout = r_dout;
  assign bus.prog_we_o = r_we_o;
  assign bus.cfg_we    = r_cfg_we;
  assign bus.cfg_addr  = r_cfg_addr;
  assign bus.cfg_data  = r_cfg_data;
  assign bus.fabric_en = r_fabric_en;
  assign bus.err       = r_err;

endmodule
